// File: rtl/seg7_bcd_scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_bcd_scan_counter                                        |
// | Description : DIGITS-wide BCD up/down counter stepped by tick_clk rising   |
// |               edges, time-multiplexed onto a common DIGITS-digit 7-segment |
// |               display, one digit per scan_clk rising edge. tick_clk and    |
// |               scan_clk are only edge-detected enable sources; every flop   |
// |               runs on clkin.                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_bcd_scan_counter #(
   parameter int DIGITS         = 4,   // 1..8
   parameter int SEG_ACTIVE_LOW = 1,   // 1: common anode, all display outputs active-low
   parameter int BLANK_LEADING  = 1    // 1: blank leading-zero digits above digit 0
) (
   input  logic                  clkin,
   input  logic                  rst,
   input  logic                  tick_clk,
   input  logic                  scan_clk,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   count,
   output logic                  carry,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an
);

   // Scan index width; a single-digit display still needs one bit to hold zero.
   localparam int              c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   // Polarity inversion mask source for every display output.
   localparam logic            c_inv     = (SEG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] c_an_off  = {DIGITS{c_inv}};
   localparam logic [6:0]        c_seg_off = {7{c_inv}};
   localparam logic            c_blank   = (BLANK_LEADING != 0);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic                 tick_d_q;     // tick_clk history for edge detect
   logic                 scan_d_q;     // scan_clk history for edge detect
   logic [4*DIGITS-1:0]  count_q, count_d;
   logic                 carry_q, carry_d;
   logic [c_idx_w-1:0]   idx_q, idx_d;
   logic [DIGITS-1:0]    an_q, an_d;
   logic [6:0]           seg_q, seg_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                 step_w;
   logic                 scan_step_w;
   logic [4*DIGITS-1:0]  inc_w, dec_w, load_clamped_w;
   logic                 inc_c_w, dec_b_w;
   logic [DIGITS-1:0]    zero_from_w;  // bit i: digits i..DIGITS-1 are all zero
   logic [DIGITS-1:0]    an_onehot_w;
   logic [3:0]           digit_w;
   logic                 blank_w;

   // Active-high {g,f,e,d,c,b,a} pattern for one BCD digit.
   function automatic logic [6:0] f_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;   // unreachable: count only ever holds valid BCD
      endcase
      return s;
   endfunction

   // Rising-edge strobes; the history flops come out of reset high so a level
   // already high at release is not mistaken for an edge.
   assign step_w      = tick_clk & ~tick_d_q & en;
   assign scan_step_w = scan_clk & ~scan_d_q;

   // BCD increment with ripple carry; inc_c_w left set means all digits were 9.
   always_comb begin
      inc_w   = count_q;
      inc_c_w = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (inc_c_w) begin
            if (count_q[4*i +: 4] == 4'd9) begin
               inc_w[4*i +: 4] = 4'd0;
            end else begin
               inc_w[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
               inc_c_w         = 1'b0;
            end
         end
      end
   end

   // BCD decrement with ripple borrow; dec_b_w left set means all digits were 0.
   always_comb begin
      dec_w   = count_q;
      dec_b_w = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (dec_b_w) begin
            if (count_q[4*i +: 4] == 4'd0) begin
               dec_w[4*i +: 4] = 4'd9;
            end else begin
               dec_w[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
               dec_b_w         = 1'b0;
            end
         end
      end
   end

   // Clamp each load digit into 0..9 so count stays valid BCD.
   always_comb begin
      load_clamped_w = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) begin
            load_clamped_w[4*i +: 4] = 4'd9;
         end
      end
   end

   // Count next-state: clear beats load beats step; carry only on a wrapping step.
   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_clamped_w;
      end else if (step_w) begin
         if (up) begin
            count_d = inc_w;
            carry_d = inc_c_w;
         end else begin
            count_d = dec_w;
            carry_d = dec_b_w;
         end
      end
   end

   // Scan index advances once per scan edge and wraps after the last digit.
   always_comb begin
      idx_d = idx_q;
      if (scan_step_w) begin
         idx_d = (idx_q == c_idx_w'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Leading-zero map, built from the most significant digit downwards.
   always_comb begin
      zero_from_w = '0;
      zero_from_w[DIGITS-1] = (count_q[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         zero_from_w[i] = zero_from_w[i+1] & (count_q[4*i +: 4] == 4'd0);
      end
   end

   // Select the scanned digit, decide blanking, and form the display next-state.
   always_comb begin
      digit_w     = 4'd0;
      blank_w     = 1'b0;
      an_onehot_w = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == c_idx_w'(i)) begin
            digit_w        = count_q[4*i +: 4];
            blank_w        = c_blank & (i != 0) & zero_from_w[i];
            an_onehot_w[i] = 1'b1;
         end
      end
      seg_d = (blank_w ? 7'h00 : f_decode(digit_w)) ^ c_seg_off;
      an_d  = an_onehot_w ^ c_an_off;
   end

   // All state registers; display outputs lag idx/count by one cycle.
   always_ff @(posedge clkin) begin
      if (rst) begin
         tick_d_q <= 1'b1;
         scan_d_q <= 1'b1;
         count_q  <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         an_q     <= c_an_off;
         seg_q    <= c_seg_off;
      end else begin
         tick_d_q <= tick_clk;
         scan_d_q <= scan_clk;
         count_q  <= count_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign count = count_q;
   assign carry = carry_q;
   assign seg   = seg_q;
   assign an    = an_q;
   assign dp    = c_inv;   // decimal point is never lit

endmodule
`default_nettype wire

// File: tb/tb_seg7_bcd_scan_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_bcd_scan_counter                                     |
// | Description : Directed self-checking bench for seg7_bcd_scan_counter with  |
// |               DIGITS=4, active-low segments and leading-zero blanking.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_bcd_scan_counter;

   logic        clkin = 1'b0;
   logic        rst, tick_clk, scan_clk, en, up, clear, load;
   logic [15:0] load_val;
   logic [15:0] count;
   logic        carry;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   int checks   = 0;
   int failures = 0;
   int n_carry;

   seg7_bcd_scan_counter #(
      .DIGITS         (4),
      .SEG_ACTIVE_LOW (1),
      .BLANK_LEADING  (1)
   ) dut (
      .clkin    (clkin),
      .rst      (rst),
      .tick_clk (tick_clk),
      .scan_clk (scan_clk),
      .en       (en),
      .up       (up),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .carry    (carry),
      .seg      (seg),
      .dp       (dp),
      .an       (an)
   );

   always #5 clkin = ~clkin;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One tick_clk rising edge; returns how many sampled cycles carry was high.
   task automatic do_tick(output int carries);
      carries = 0;
      @(negedge clkin) tick_clk = 1'b1;
      repeat (3) begin
         @(negedge clkin);
         if (carry) carries++;
      end
      tick_clk = 1'b0;
      repeat (2) begin
         @(negedge clkin);
         if (carry) carries++;
      end
   endtask

   // Single-cycle synchronous load.
   task automatic do_load(input logic [15:0] v);
      @(negedge clkin);
      load     = 1'b1;
      load_val = v;
      @(negedge clkin);
      load     = 1'b0;
   endtask

   // One scan_clk rising edge; on return idx has advanced and an/seg follow it.
   task automatic scan_pulse();
      @(negedge clkin) scan_clk = 1'b1;
      @(negedge clkin);
      @(negedge clkin) scan_clk = 1'b0;
      @(negedge clkin);
   endtask

   // Hard time bound so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int total;
      rst = 1'b1; tick_clk = 1'b0; scan_clk = 1'b0; en = 1'b0; up = 1'b1;
      clear = 1'b0; load = 1'b0; load_val = 16'h0000;
      repeat (3) @(negedge clkin);

      // Reset state: everything inactive (active-low => all ones).
      check("rst_count", 32'(count), 32'h0000);
      check("rst_carry", 32'(carry), 32'h0);
      check("rst_an",    32'(an),    32'hF);
      check("rst_seg",   32'(seg),   32'h7F);
      check("rst_dp",    32'(dp),    32'h1);

      rst = 1'b0;
      en  = 1'b1;
      up  = 1'b1;

      // 12 up-steps from zero: no wrap anywhere.
      total = 0;
      repeat (12) begin
         do_tick(n_carry);
         total += n_carry;
      end
      check("up12_count", 32'(count), 32'h0012);
      check("up12_carry", 32'(total), 32'd0);

      // All-9s wraps to zero with a single-cycle carry pulse.
      do_load(16'h9999);
      check("load9999", 32'(count), 32'h9999);
      do_tick(n_carry);
      check("wrap_up_count", 32'(count), 32'h0000);
      check("wrap_up_carry", 32'(n_carry), 32'd1);

      // Zero decrements to all-9s with a single-cycle borrow pulse.
      up = 1'b0;
      do_tick(n_carry);
      check("wrap_dn_count", 32'(count), 32'h9999);
      check("wrap_dn_carry", 32'(n_carry), 32'd1);

      // Out-of-range digits A and F clamp to 9.
      do_load(16'hA3F1);
      check("load_clamp", 32'(count), 32'h9391);

      // Clear together with a tick edge: clear wins, the step is lost.
      up = 1'b1;
      @(negedge clkin);
      clear    = 1'b1;
      tick_clk = 1'b1;
      @(negedge clkin);
      clear    = 1'b0;
      check("clr_tick", 32'(count), 32'h0000);
      repeat (2) @(negedge clkin);
      tick_clk = 1'b0;
      repeat (2) @(negedge clkin);
      check("clr_drop", 32'(count), 32'h0000);

      // en=0 holds the count through 5 edges; then a down step with borrow.
      do_load(16'h0123);
      en = 1'b0;
      repeat (5) do_tick(n_carry);
      check("en0_hold", 32'(count), 32'h0123);
      en = 1'b1;
      up = 1'b0;
      do_tick(n_carry);
      check("dn_step", 32'(count), 32'h0122);
      do_load(16'h0100);
      do_tick(n_carry);
      check("dn_borrow", 32'(count), 32'h0099);

      // Scan 0x0042: "2" (5B -> ~ = 24), "4" (66 -> ~ = 19), blank, blank.
      en = 1'b0;
      do_load(16'h0042);
      @(negedge clkin);
      check("scan0_an",  32'(an),  32'hE);
      check("scan0_seg", 32'(seg), 32'h24);
      scan_pulse();
      check("scan1_an",  32'(an),  32'hD);
      check("scan1_seg", 32'(seg), 32'h19);
      scan_pulse();
      check("scan2_an",  32'(an),  32'hB);
      check("scan2_seg", 32'(seg), 32'h7F);
      scan_pulse();
      check("scan3_an",  32'(an),  32'h7);
      check("scan3_seg", 32'(seg), 32'h7F);
      scan_pulse();
      check("scan4_an",  32'(an),  32'hE);
      check("scan4_seg", 32'(seg), 32'h24);

      // Inner zero of 0x1002 is not leading, so it shows "0" (3F -> ~ = 40).
      do_load(16'h1002);
      @(negedge clkin);
      check("mid0_seg", 32'(seg), 32'h24);
      scan_pulse();
      check("mid1_an",  32'(an),  32'hD);
      check("mid1_seg", 32'(seg), 32'h40);
      scan_pulse();
      scan_pulse();
      check("mid3_seg", 32'(seg), 32'h79);   // "1": 06 -> ~ = 79

      // Reset mid-scan with tick_clk held high through release.
      en = 1'b1;
      up = 1'b1;
      @(negedge clkin);
      rst      = 1'b1;
      tick_clk = 1'b1;
      @(negedge clkin);
      check("midrst_an",    32'(an),    32'hF);
      check("midrst_seg",   32'(seg),   32'h7F);
      check("midrst_count", 32'(count), 32'h0000);
      repeat (2) @(negedge clkin);
      rst = 1'b0;
      repeat (3) @(negedge clkin);
      check("rel_nostep", 32'(count), 32'h0000);
      check("rel_an",     32'(an),    32'hE);
      check("rel_seg",    32'(seg),   32'h40);
      tick_clk = 1'b0;
      do_tick(n_carry);
      check("rel_fresh", 32'(count), 32'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
